// File: rtl/e203_cmt_result_mon.sv
// Commit-stream result monitor: counts cycles/dispatches, detects tohost hits,
// declares pass/fail/timeout from x3, and keeps a short committed-PC history.
//
// state | meaning
// RUN   | test in progress, counters and history updating
// DONE  | DONE_CNT-th tohost hit seen, pass/fail latched from x3
// TMO   | cycle budget exhausted before the test finished
module e203_cmt_result_mon #(
    parameter int                PC_W       = 32,
    parameter int                XLEN       = 32,
    parameter logic [PC_W-1:0]   TOHOST_PC  = PC_W'(32'h8000_0086),
    parameter int                DONE_CNT   = 8,
    parameter logic [31:0]       TIMEOUT    = 32'd10000000,
    parameter int                HIST_DEPTH = 4,
    localparam int               HW         = $clog2(HIST_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            cmt_valid,
    input  logic [PC_W-1:0] cmt_pc,
    input  logic            exu_i_valid,
    input  logic            exu_i_ready,
    input  logic [XLEN-1:0] x3_val,
    input  logic [HW-1:0]   hist_idx,
    output logic [PC_W-1:0] hist_pc,
    output logic [HW:0]     hist_cnt,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instr_cnt,
    output logic [31:0]     tohost_cnt,
    output logic [31:0]     tohost_cycle,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic            timeout
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DONE = 2'd1,
        S_TMO  = 2'd2
    } state_t;

    localparam logic [31:0] DONE_LAST = 32'(DONE_CNT - 1);
    localparam logic [HW:0] HIST_FULL = (HW + 1)'(HIST_DEPTH);

    state_t          state;
    logic [PC_W-1:0] hist_mem [HIST_DEPTH];
    logic [HW-1:0]   wr_ptr;
    logic [HW-1:0]   rd_addr;
    logic            hit;
    logic            seen;
    logic            done_hit;
    logic            x3_is_one;

    assign hit       = cmt_valid && (cmt_pc == TOHOST_PC);
    assign seen      = (tohost_cnt != 32'd0);
    assign done_hit  = hit && (tohost_cnt == DONE_LAST);
    assign x3_is_one = (x3_val == XLEN'(1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state        <= S_RUN;
            cycle_cnt    <= '0;
            instr_cnt    <= '0;
            tohost_cnt   <= '0;
            tohost_cycle <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            wr_ptr       <= '0;
            hist_cnt     <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
        end else if (state == S_RUN) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (exu_i_valid && exu_i_ready && !seen)
                instr_cnt <= instr_cnt + 32'd1;
            if (hit) begin
                tohost_cnt <= tohost_cnt + 32'd1;
                if (!seen) tohost_cycle <= cycle_cnt;
            end
            // Ring buffer: oldest entry is overwritten once full.
            if (cmt_valid) begin
                hist_mem[wr_ptr] <= cmt_pc;
                wr_ptr           <= wr_ptr + 1'b1;
                if (hist_cnt != HIST_FULL) hist_cnt <= hist_cnt + 1'b1;
            end
            // A completing hit takes priority over a coincident timeout.
            if (done_hit) begin
                state <= S_DONE;
                done  <= 1'b1;
                pass  <= x3_is_one;
                fail  <= !x3_is_one;
            end else if (cycle_cnt == TIMEOUT - 32'd1) begin
                state   <= S_TMO;
                done    <= 1'b1;
                timeout <= 1'b1;
                fail    <= 1'b1;
            end
        end
    end

    // Newest entry sits just behind the write pointer.
    assign rd_addr = wr_ptr - HW'(1) - hist_idx;
    assign hist_pc = ({1'b0, hist_idx} < hist_cnt) ? hist_mem[rd_addr] : '0;

endmodule

// File: tb/tb_e203_cmt_result_mon.sv
// Directed bench for e203_cmt_result_mon with a queue-based reference model
// checked every cycle, plus literal checkpoints from the hand-worked scenarios.
module tb_e203_cmt_result_mon;

    localparam logic [31:0] HIT_PC   = 32'h8000_0086;
    localparam int          DONE_N   = 8;
    localparam logic [31:0] TMO_N    = 32'd100;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        cmt_valid = 1'b0;
    logic [31:0] cmt_pc = '0;
    logic        exu_i_valid = 1'b0;
    logic        exu_i_ready = 1'b0;
    logic [31:0] x3_val = '0;
    logic [1:0]  hist_idx = '0;
    logic [31:0] hist_pc;
    logic [2:0]  hist_cnt;
    logic [31:0] cycle_cnt, instr_cnt, tohost_cnt, tohost_cycle;
    logic        done, pass, fail, timeout;

    e203_cmt_result_mon #(
        .PC_W(32), .XLEN(32), .TOHOST_PC(HIT_PC), .DONE_CNT(DONE_N),
        .TIMEOUT(TMO_N), .HIST_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
        .exu_i_valid(exu_i_valid), .exu_i_ready(exu_i_ready),
        .x3_val(x3_val), .hist_idx(hist_idx), .hist_pc(hist_pc),
        .hist_cnt(hist_cnt), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
        .tohost_cnt(tohost_cnt), .tohost_cycle(tohost_cycle),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: test-level bookkeeping with a newest-first PC queue.
    bit          m_live = 0;
    bit          m_ended = 0;
    logic [31:0] m_cycles, m_instrs, m_hits, m_first_hit_cycle;
    bit          m_pass, m_fail, m_tmo;
    logic [31:0] m_hist [$];

    always @(posedge clk) begin
        if (!rst_n || clr) begin
            m_live = 1; m_ended = 0;
            m_cycles = 0; m_instrs = 0; m_hits = 0; m_first_hit_cycle = 0;
            m_pass = 0; m_fail = 0; m_tmo = 0;
            m_hist.delete();
        end else if (m_live && !m_ended) begin
            automatic logic [31:0] cyc_now = m_cycles;
            automatic bit is_hit = cmt_valid && (cmt_pc == HIT_PC);
            if (exu_i_valid && exu_i_ready && m_hits == 0) m_instrs = m_instrs + 1;
            if (is_hit) begin
                if (m_hits == 0) m_first_hit_cycle = cyc_now;
                m_hits = m_hits + 1;
            end
            if (cmt_valid) begin
                m_hist.push_front(cmt_pc);
                if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
            end
            m_cycles = cyc_now + 1;
            if (is_hit && m_hits == DONE_N) begin
                m_ended = 1;
                m_pass = (x3_val == 1);
                m_fail = !m_pass;
            end else if (m_cycles == TMO_N) begin
                m_ended = 1; m_tmo = 1; m_fail = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            automatic logic [31:0] exp_pc = (hist_idx < m_hist.size()) ? m_hist[hist_idx] : 32'd0;
            chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cycles));
            chk("instr_cnt", 64'(instr_cnt), 64'(m_instrs));
            chk("tohost_cnt", 64'(tohost_cnt), 64'(m_hits));
            chk("tohost_cycle", 64'(tohost_cycle), 64'(m_first_hit_cycle));
            chk("done", 64'(done), 64'(m_ended));
            chk("pass", 64'(pass), 64'(m_pass));
            chk("fail", 64'(fail), 64'(m_fail));
            chk("timeout", 64'(timeout), 64'(m_tmo));
            chk("hist_cnt", 64'(hist_cnt), 64'(m_hist.size()));
            chk("hist_pc", 64'(hist_pc), 64'(exp_pc));
        end
    end

    task automatic cyc(input logic cv, input logic [31:0] pc, input logic hs, input logic [31:0] x3);
        cmt_valid = cv; cmt_pc = pc;
        exu_i_valid = hs; exu_i_ready = hs;
        x3_val = x3;
        hist_idx = hist_idx + 2'd1;
        @(posedge clk); #1;
        cmt_valid = 1'b0; exu_i_valid = 1'b0; exu_i_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, x3_val);
    endtask

    task automatic do_clr(input logic with_hit);
        clr = 1'b1;
        cyc(with_hit, HIT_PC, 1'b0, 32'd1);
        clr = 1'b0;
    endtask

    initial begin
        // Reset then 5 idle RUN cycles
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        chk("lit_idle_cycle", 64'(cycle_cnt), 64'd5);
        chk("lit_idle_instr", 64'(instr_cnt), 64'd0);
        chk("lit_idle_flags", 64'({done, pass, fail, timeout, hist_cnt}), 64'd0);

        // 10 handshakes (with commits), hit at sampled cycle 20, 3 more handshakes
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h8000_0100 + 32'(4 * i), 1'b1, 32'd0);
        idle(5);
        cyc(1'b1, HIT_PC, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 32'd0);
        chk("lit_instr_cnt", 64'(instr_cnt), 64'd10);
        chk("lit_tohost_cycle", 64'(tohost_cycle), 64'd20);
        chk("lit_tohost_cnt1", 64'(tohost_cnt), 64'd1);

        // Hits 2..8, x3 = 1 on the 8th -> pass; 9th hit ignored
        for (int i = 2; i <= 7; i++) cyc(1'b1, HIT_PC, 1'b0, 32'd0);
        chk("lit_not_done_7", 64'(done), 64'd0);
        cyc(1'b1, HIT_PC, 1'b0, 32'd1);
        chk("lit_pass_flags", 64'({done, pass, fail, timeout}), 64'b1100);
        cyc(1'b1, HIT_PC, 1'b1, 32'd0);
        idle(3);
        chk("lit_frozen_hits", 64'(tohost_cnt), 64'd8);
        chk("lit_frozen_cycle", 64'(cycle_cnt), 64'd31);

        // clr coincident with a hit: nothing counted; then 8 hits with x3 = 0
        do_clr(1'b1);
        chk("lit_clr_hit", 64'({tohost_cnt, cycle_cnt}), 64'd0);
        for (int i = 1; i <= 8; i++) cyc(1'b1, HIT_PC, 1'b0, 32'd0);
        chk("lit_fail_flags", 64'({done, pass, fail, timeout}), 64'b1010);
        x3_val = 32'd1;
        idle(3);
        cyc(1'b1, HIT_PC, 1'b0, 32'd1);
        chk("lit_fail_sticky", 64'({pass, fail, cycle_cnt}), {32'd1, 32'd8});

        // Pure timeout
        do_clr(1'b0);
        idle(100);
        chk("lit_tmo_flags", 64'({done, pass, fail, timeout}), 64'b1011);
        chk("lit_tmo_cycle", 64'(cycle_cnt), 64'd100);

        // 8th hit on the timeout edge: DONE wins
        do_clr(1'b0);
        for (int i = 1; i <= 7; i++) cyc(1'b1, HIT_PC, 1'b0, 32'd0);
        idle(92);
        chk("lit_pre_cycle99", 64'({done, cycle_cnt}), 64'd99);
        cyc(1'b1, HIT_PC, 1'b0, 32'd1);
        chk("lit_race_flags", 64'({done, pass, fail, timeout}), 64'b1100);
        chk("lit_race_cycle", 64'(cycle_cnt), 64'd100);

        // History wrap
        do_clr(1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0, 32'd0);
        hist_idx = 2'd0; #1;
        chk("lit_hist_cnt", 64'(hist_cnt), 64'd4);
        chk("lit_hist_idx0", 64'(hist_pc), 64'h8000_0010);
        hist_idx = 2'd3; #1;
        chk("lit_hist_idx3", 64'(hist_pc), 64'h8000_0004);
        @(negedge clk);
        do_clr(1'b0);
        hist_idx = 2'd0; #1;
        chk("lit_hist_clr", 64'({hist_cnt, hist_pc}), 64'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
